// File: rtl/compare_unit_if.sv
// compare_unit_if: CP0 Compare-stage bus between the Count/CP0 side (master)
// and the compare unit (slave).
//   master drives : count, count_upd, we_cmp, r_cmp, wdata, int_ack, ie
//                   (+ we_per when CMP_PERIODIC_EN is defined)
//   master reads  : read_data, timer_int, miss_cnt
// Optional feature macro: CMP_PERIODIC_EN (adds we_per).
interface compare_unit_if #(
  parameter int WIDTH     = 32,
  parameter int MISS_BITS = 4
);
  logic [WIDTH-1:0]     count;
  logic                 count_upd;
  logic                 we_cmp;
  logic                 r_cmp;
  logic [WIDTH-1:0]     wdata;
  logic                 int_ack;
  logic                 ie;
`ifdef CMP_PERIODIC_EN
  logic                 we_per;
`endif
  logic [WIDTH-1:0]     read_data;
  logic                 timer_int;
  logic [MISS_BITS-1:0] miss_cnt;

  modport master (
`ifdef CMP_PERIODIC_EN
    output we_per,
`endif
    output count, count_upd, we_cmp, r_cmp, wdata, int_ack, ie,
    input  read_data, timer_int, miss_cnt
  );

  modport slave (
`ifdef CMP_PERIODIC_EN
    input  we_per,
`endif
    input  count, count_upd, we_cmp, r_cmp, wdata, int_ack, ie,
    output read_data, timer_int, miss_cnt
  );
endinterface

// File: rtl/compare_unit.sv
// compare_unit: CP0 Compare register and timer interrupt (IP7) generation.
// Watches the Count value and raises timer_int when Count advances onto
// Compare. Serves CP0 reads/writes of Compare.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - compare_unit_if.slave (count/count_upd/we_cmp/r_cmp/wdata/
//          int_ack/ie in; read_data/timer_int/miss_cnt out)
// Optional feature macro: CMP_PERIODIC_EN (Period register, we_per port,
// auto-reload of Compare on hit).
//
// state     | meaning
// ----------+-------------------------------------------------------------
// DISARMED  | Compare never written since reset; matches are ignored
// ARMED     | waiting for Count to advance onto Compare
// FIRED     | one-shot match taken; waiting for int_ack or a Compare write
`ifndef UNKNOW
`define UNKNOW 'x
`endif

module compare_unit #(
  parameter int WIDTH     = 32,
  parameter int MISS_BITS = 4
) (
  input  logic          clk,
  input  logic          rst,
  compare_unit_if.slave bus
);

  typedef enum logic [1:0] {
    S_DISARMED = 2'd0,
    S_ARMED    = 2'd1,
    S_FIRED    = 2'd2
  } state_t;

  state_t               state_q,     state_d;
  logic [WIDTH-1:0]     compare_q,   compare_d;
  logic                 pending_q,   pending_d;
  logic [MISS_BITS-1:0] miss_q,      miss_d;
  logic                 timer_int_q, timer_int_d;
  logic                 hit;
  logic                 reload;
`ifdef CMP_PERIODIC_EN
  logic [WIDTH-1:0]     period_q,    period_d;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_DISARMED;
      compare_q   <= '0;
      pending_q   <= 1'b0;
      miss_q      <= '0;
      timer_int_q <= 1'b0;
`ifdef CMP_PERIODIC_EN
      period_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      compare_q   <= compare_d;
      pending_q   <= pending_d;
      miss_q      <= miss_d;
      timer_int_q <= timer_int_d;
`ifdef CMP_PERIODIC_EN
      period_q    <= period_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    compare_d = compare_q;
    pending_d = pending_q;
    miss_d    = miss_q;
`ifdef CMP_PERIODIC_EN
    period_d  = period_q;
    if (bus.we_per) period_d = bus.wdata;
    // A zero period degenerates to one-shot behaviour.
    reload    = (period_q != '0);
`else
    reload    = 1'b0;
`endif

    hit = bus.count_upd && (bus.count == compare_q) && (state_q != S_DISARMED);

    if (bus.we_cmp) begin
      compare_d = bus.wdata;
      pending_d = 1'b0;
      state_d   = S_ARMED;
    end else if (hit && reload) begin
      // Periodic hit survives a simultaneous ack; the ack consumes the old
      // request, so the new hit is not counted as missed in that case.
      if (pending_q && !bus.int_ack && (miss_q != {MISS_BITS{1'b1}}))
        miss_d = miss_q + 1'b1;
`ifdef CMP_PERIODIC_EN
      compare_d = compare_q + period_q;
`endif
      pending_d = 1'b1;
      state_d   = S_ARMED;
    end else if (bus.int_ack) begin
      pending_d = 1'b0;
      if (state_q == S_FIRED) state_d = S_ARMED;
    end else if (hit) begin
      if (pending_q && (miss_q != {MISS_BITS{1'b1}}))
        miss_d = miss_q + 1'b1;
      pending_d = 1'b1;
      state_d   = S_FIRED;
    end

    timer_int_d = pending_d && bus.ie;
  end

  assign bus.read_data = bus.r_cmp ? compare_q : `UNKNOW;
  assign bus.timer_int = timer_int_q;
  assign bus.miss_cnt  = miss_q;

endmodule

// File: tb/tb_compare_unit.sv
module tb_compare_unit;
  localparam int W     = 8;
  localparam int MB    = 4;
  localparam int MSAT  = (1 << MB) - 1;
  localparam int WMOD  = 1 << W;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  compare_unit_if #(.WIDTH(W), .MISS_BITS(MB)) bus ();
  compare_unit #(.WIDTH(W), .MISS_BITS(MB)) dut (.clk(clk), .rst(rst_n), .bus(bus));

  int total = 0;
  int bad   = 0;

  // Reference model: "written" replaces the FSM -- once Compare has been
  // written, any count_upd onto Compare is a match.
  int m_cmp, m_per, m_miss;
  bit m_written, m_pend, m_tint;

  task automatic chk(string tag, int obs, int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cmp = 0; m_per = 0; m_miss = 0;
    m_written = 0; m_pend = 0; m_tint = 0;
  endtask

  task automatic model_step();
    bit match, periodic;
    int per_in;
    match    = m_written && bus.count_upd && (int'(bus.count) == m_cmp);
    periodic = (m_per != 0);
    per_in   = m_per;
`ifdef CMP_PERIODIC_EN
    if (bus.we_per) per_in = int'(bus.wdata);
`endif
    if (bus.we_cmp) begin
      m_cmp = int'(bus.wdata); m_pend = 0; m_written = 1;
    end else if (match && (periodic || !bus.int_ack)) begin
      if (m_pend && !bus.int_ack && m_miss < MSAT) m_miss++;
      m_pend = 1;
      if (periodic) m_cmp = (m_cmp + m_per) % WMOD;
    end else if (bus.int_ack) begin
      m_pend = 0;
    end
    m_per  = per_in;
    m_tint = m_pend && bus.ie;
  endtask

  task automatic clr_in();
    bus.count_upd = 0; bus.we_cmp = 0; bus.r_cmp = 0;
    bus.wdata = '0; bus.int_ack = 0;
`ifdef CMP_PERIODIC_EN
    bus.we_per = 0;
`endif
  endtask

  task automatic cyc(string tag);
    model_step();
    @(posedge clk);
    #1;
    chk({tag, "_tint"}, int'(bus.timer_int), int'(m_tint));
    chk({tag, "_miss"}, int'(bus.miss_cnt), m_miss);
    if (bus.r_cmp) chk({tag, "_rd"}, int'(bus.read_data), m_cmp);
  endtask

  task automatic step_count(int c, string tag);
    clr_in();
    bus.count = W'(c); bus.count_upd = 1;
    cyc(tag);
  endtask

  task automatic write_cmp(int v, string tag);
    clr_in();
    bus.we_cmp = 1; bus.wdata = W'(v);
    cyc(tag);
  endtask

  task automatic ack(string tag);
    clr_in();
    bus.int_ack = 1;
    cyc(tag);
  endtask

  initial begin
    model_reset();
    clr_in();
    bus.count = '0; bus.ie = 0;
    #2;
    bus.r_cmp = 1;
    #1;
    chk("rst_tint", int'(bus.timer_int), 0);
    chk("rst_miss", int'(bus.miss_cnt), 0);
    chk("rst_rd",   int'(bus.read_data), 0);
    #9 rst_n = 1;
    @(posedge clk); #1;

    // 1: no match while never written
    bus.ie = 1;
    for (int i = 0; i <= 20; i++) step_count(i, "t1");
    chk("t1_quiet", int'(bus.timer_int), 0);

    // 2: compare=10, count 5..12
    write_cmp(10, "t2w");
    for (int i = 5; i <= 12; i++) begin
      step_count(i, "t2");
      if (i == 10) chk("t2_fire", int'(bus.timer_int), 1);
    end
    ack("t2a");
    chk("t2_ack", int'(bus.timer_int), 0);

    // 3: write compare equal to current count, then a full wrap
    clr_in();
    bus.count = 8'd7; bus.count_upd = 1; bus.we_cmp = 1; bus.wdata = 8'd7;
    cyc("t3w");
    chk("t3_nofire", int'(bus.timer_int), 0);
    step_count(8, "t3");
    chk("t3_still0", int'(bus.timer_int), 0);
    for (int i = 9; i < WMOD + 8; i++) step_count(i % WMOD, "t3wrap");
    chk("t3_wrapfire", int'(bus.timer_int), 1);
    ack("t3a");

    // 4: hit and write in the same cycle
    write_cmp(20, "t4w");
    step_count(19, "t4");
    clr_in();
    bus.count = 8'd20; bus.count_upd = 1; bus.we_cmp = 1; bus.wdata = 8'd50;
    cyc("t4hw");
    clr_in();
    bus.r_cmp = 1;
    cyc("t4r");
    chk("t4_rd50", int'(bus.read_data), 50);
    chk("t4_nopend", int'(bus.timer_int), 0);

    // 5: masked hit, unmask, missed hits with saturation
    bus.ie = 0;
    step_count(50, "t5");
    chk("t5_masked", int'(bus.timer_int), 0);
    clr_in(); bus.ie = 1;
    cyc("t5ie");
    chk("t5_unmask", int'(bus.timer_int), 1);
    step_count(50, "t5m");
    chk("t5_miss1", int'(bus.miss_cnt), 1);
    for (int i = 0; i < 20; i++) step_count(50, "t5s");
    chk("t5_sat", int'(bus.miss_cnt), MSAT);
    ack("t5a");

`ifdef CMP_PERIODIC_EN
    // 6: periodic reload
    clr_in(); bus.we_per = 1; bus.wdata = 8'd25;
    cyc("t6p");
    write_cmp(100, "t6w");
    for (int i = 95; i <= 160; i++) begin
      step_count(i, "t6");
      bus.r_cmp = 1; #1;
      if (i == 100) chk("t6_rd125", int'(bus.read_data), 125);
      if (i == 150) chk("t6_rd175", int'(bus.read_data), 175);
      if (bus.timer_int) ack("t6a");
    end
    clr_in(); bus.we_per = 1; bus.wdata = 8'h20;
    cyc("t6p2");
    write_cmp(8'hF0, "t6w2");
    step_count(8'hF0, "t6h");
    clr_in(); bus.r_cmp = 1;
    cyc("t6r");
    chk("t6_wrap", int'(bus.read_data), 8'h10);
    ack("t6a2");
`endif

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      clr_in();
      bus.count     = W'($urandom_range(0, 7));
      bus.count_upd = 1'($urandom_range(0, 1));
      bus.we_cmp    = ($urandom_range(0, 15) == 0);
      bus.wdata     = W'($urandom_range(0, 7));
      bus.int_ack   = ($urandom_range(0, 7) == 0);
      bus.ie        = ($urandom_range(0, 3) != 0);
      bus.r_cmp     = 1'($urandom_range(0, 1));
`ifdef CMP_PERIODIC_EN
      bus.we_per    = ($urandom_range(0, 15) == 0);
`endif
      cyc("rnd");
    end

    // reset mid-run with a pending request
    bus.ie = 1;
    write_cmp(3, "mrw");
    step_count(3, "mrh");
    step_count(3, "mrh2");
    chk("mr_pend", int'(bus.timer_int), 1);
    clr_in(); bus.r_cmp = 1;
    #2 rst_n = 0;
    #1;
    chk("mr_tint", int'(bus.timer_int), 0);
    chk("mr_miss", int'(bus.miss_cnt), 0);
    chk("mr_rd",   int'(bus.read_data), 0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
